// File: rtl/ldtu_ham_decoder.sv
// Read-side controller for the LiTe-DTU storage FIFO: Hamming(38,32) single-error correction into a 2-entry valid/ready buffer.
// Latency: read_signal cycle N -> data_valid cycle N+2; reads issued only when a buffer slot is guaranteed. Optional: LDTU_ERR_COUNT_EN.
module ldtu_ham_decoder #(
  parameter int Nbits_ham  = 38,
  parameter int Nbits_data = 32,
  parameter int Cnt_bits   = 8
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  empty_signal,
  input  logic                  decode_signal,
  input  logic [Nbits_ham-1:0]  data_input,
  output logic                  read_signal,
  input  logic                  data_ready,
  output logic                  data_valid,
  output logic [Nbits_data-1:0] data_output,
  output logic                  corr_flag,
  output logic                  uncorr_flag,
  output logic [Cnt_bits-1:0]   corr_count,
  output logic [Cnt_bits-1:0]   uncorr_count
);

  logic [5:0]            syn;
  logic [Nbits_ham-1:0]  fixed_cw;
  logic [Nbits_data-1:0] dec_data;
  logic                  dec_corr;
  logic                  dec_uncorr;

  // Syndrome is the XOR of the 1-based positions of every set bit.
  always_comb begin
    syn = '0;
    for (int i = 0; i < Nbits_ham; i++) begin
      if (data_input[i]) syn = syn ^ 6'(i + 1);
    end
    dec_corr   = (syn != 6'd0) && (syn <= 6'(Nbits_ham));
    dec_uncorr = (syn > 6'(Nbits_ham));
    fixed_cw   = data_input;
    for (int i = 0; i < Nbits_ham; i++) begin
      if (dec_corr && (syn == 6'(i + 1))) fixed_cw[i] = ~data_input[i];
    end
    dec_data = {fixed_cw[37:32], fixed_cw[30:16], fixed_cw[14:8], fixed_cw[6:4], fixed_cw[2]};
  end

  logic [Nbits_data-1:0] b0_dat, b1_dat;
  logic                  b0_corr, b0_uncorr, b1_corr, b1_uncorr;
  logic [1:0]            count;
  logic                  pending;
  logic                  push;
  logic                  pop;

  assign push        = decode_signal & pending;
  assign data_valid  = (count != 2'd0);
  assign pop         = data_valid & data_ready;
  assign data_output = b0_dat;
  assign corr_flag   = data_valid & b0_corr;
  assign uncorr_flag = data_valid & b0_uncorr;

  // A slot is reserved for every read still in flight, so a push never finds the buffer full.
  assign read_signal = !reset && !empty_signal &&
                       (({1'b0, count} + {2'b00, pending}) < (3'd2 + {2'b00, pop}));

  always_ff @(posedge CLK) begin
    if (reset) begin
      count     <= 2'd0;
      pending   <= 1'b0;
      b0_dat    <= '0;
      b1_dat    <= '0;
      b0_corr   <= 1'b0;
      b0_uncorr <= 1'b0;
      b1_corr   <= 1'b0;
      b1_uncorr <= 1'b0;
    end else begin
      pending <= read_signal;
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            b0_dat    <= dec_data;
            b0_corr   <= dec_corr;
            b0_uncorr <= dec_uncorr;
          end else begin
            b1_dat    <= dec_data;
            b1_corr   <= dec_corr;
            b1_uncorr <= dec_uncorr;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          b0_dat    <= b1_dat;
          b0_corr   <= b1_corr;
          b0_uncorr <= b1_uncorr;
          count     <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            b0_dat    <= dec_data;
            b0_corr   <= dec_corr;
            b0_uncorr <= dec_uncorr;
          end else begin
            b0_dat    <= b1_dat;
            b0_corr   <= b1_corr;
            b0_uncorr <= b1_uncorr;
            b1_dat    <= dec_data;
            b1_corr   <= dec_corr;
            b1_uncorr <= dec_uncorr;
          end
        end
        default: begin
        end
      endcase
    end
  end

`ifdef LDTU_ERR_COUNT_EN
  logic [Cnt_bits-1:0] corr_cnt_q, uncorr_cnt_q;

  always_ff @(posedge CLK) begin
    if (reset) begin
      corr_cnt_q   <= '0;
      uncorr_cnt_q <= '0;
    end else begin
      if (push && dec_corr && (corr_cnt_q != '1))     corr_cnt_q   <= corr_cnt_q + 1'b1;
      if (push && dec_uncorr && (uncorr_cnt_q != '1)) uncorr_cnt_q <= uncorr_cnt_q + 1'b1;
    end
  end

  assign corr_count   = corr_cnt_q;
  assign uncorr_count = uncorr_cnt_q;
`else
  assign corr_count   = '0;
  assign uncorr_count = '0;
`endif

endmodule

// File: tb/tb_ldtu_ham_decoder.sv
// Randomized bench for ldtu_ham_decoder: FIFO model, Hamming encoder/error injector and in-order scoreboard.
module tb_ldtu_ham_decoder;

  typedef struct packed {
    logic [31:0] d;
    logic        c;
    logic        u;
  } exp_t;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        empty_signal = 1'b1;
  logic        decode_signal = 1'b0;
  logic [37:0] data_input = '0;
  logic        read_signal;
  logic        data_ready = 1'b0;
  logic        data_valid;
  logic [31:0] data_output;
  logic        corr_flag;
  logic        uncorr_flag;
  logic [7:0]  corr_count;
  logic [7:0]  uncorr_count;

  ldtu_ham_decoder dut (
    .CLK          (CLK),
    .reset        (reset),
    .empty_signal (empty_signal),
    .decode_signal(decode_signal),
    .data_input   (data_input),
    .read_signal  (read_signal),
    .data_ready   (data_ready),
    .data_valid   (data_valid),
    .data_output  (data_output),
    .corr_flag    (corr_flag),
    .uncorr_flag  (uncorr_flag),
    .corr_count   (corr_count),
    .uncorr_count (uncorr_count)
  );

  always #5 CLK = ~CLK;

  logic [37:0] fifo_q[$];
  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          n_reads = 0;
  int          n_del = 0;
  int          n_corr = 0;
  int          n_uncorr = 0;
  logic        s_rd = 1'b0;
  logic        s_vld, s_corr, s_uncorr;
  logic [31:0] s_dat;
  logic [7:0]  s_ccnt, s_ucnt;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, want);
    end
  endtask

  function automatic bit is_pow2(input int p);
    return (p & (p - 1)) == 0;
  endfunction

  // Index of data bit carried at Hamming position p, -1 for parity positions.
  function automatic int didx(input int p);
    int k = 0;
    if (is_pow2(p)) return -1;
    for (int q = 1; q < p; q++) if (!is_pow2(q)) k++;
    return k;
  endfunction

  function automatic logic [37:0] encode(input logic [31:0] d);
    logic [37:0] cw = '0;
    logic [5:0]  s = '0;
    int          k = 0;
    for (int p = 1; p <= 38; p++) begin
      if (!is_pow2(p)) begin
        cw[p-1] = d[k];
        if (d[k]) s = s ^ 6'(p);
        k++;
      end
    end
    for (int b = 0; b < 6; b++) if (s[b]) cw[(1 << b) - 1] = 1'b1;
    return cw;
  endfunction

  function automatic logic [7:0] exp_cnt(input int n);
`ifdef LDTU_ERR_COUNT_EN
    return (n > 255) ? 8'hFF : 8'(n);
`else
    return (n < 0) ? 8'h01 : 8'h00;
`endif
  endfunction

  task automatic load(input logic [37:0] cw, input exp_t e);
    fifo_q.push_back(cw);
    exp_q.push_back(e);
    empty_signal = 1'b0;
  endtask

  // kind 0: clean, 1: single-bit error, 2: double error with syndrome beyond 38
  task automatic gen_word(input int kind);
    logic [31:0] d;
    logic [37:0] cw;
    exp_t        e;
    int          p1, p2;
    d   = $urandom;
    cw  = encode(d);
    e.d = d;
    e.c = 1'b0;
    e.u = 1'b0;
    if (kind == 1) begin
      p1 = $urandom_range(1, 38);
      cw[p1-1] = ~cw[p1-1];
      e.c = 1'b1;
    end else if (kind == 2) begin
      do begin
        p1 = $urandom_range(1, 38);
        p2 = $urandom_range(1, 38);
      end while (p1 == p2 || (p1 ^ p2) <= 38);
      cw[p1-1] = ~cw[p1-1];
      cw[p2-1] = ~cw[p2-1];
      e.u = 1'b1;
      if (didx(p1) >= 0) e.d[didx(p1)] = ~e.d[didx(p1)];
      if (didx(p2) >= 0) e.d[didx(p2)] = ~e.d[didx(p2)];
    end
    load(cw, e);
  endtask

  // Sample at the falling edge, then answer the FIFO read just after the rising edge.
  task automatic tick();
    exp_t e;
    @(negedge CLK);
    s_rd     = read_signal;
    s_vld    = data_valid;
    s_dat    = data_output;
    s_corr   = corr_flag;
    s_uncorr = uncorr_flag;
    s_ccnt   = corr_count;
    s_ucnt   = uncorr_count;
    if (s_rd) n_reads++;
    if (data_valid && data_ready) begin
      n_del++;
      if (exp_q.size() == 0) chk("unexpected_word", data_valid, 1'b0);
      else begin
        e = exp_q.pop_front();
        chk("data", data_output, e.d);
        chk("corr_flag", corr_flag, e.c);
        chk("uncorr_flag", uncorr_flag, e.u);
        if (e.c) n_corr++;
        if (e.u) n_uncorr++;
      end
    end
    @(posedge CLK);
    #1;
    if (s_rd && fifo_q.size() > 0) begin
      data_input    = fifo_q.pop_front();
      decode_signal = 1'b1;
    end else begin
      decode_signal = 1'b0;
    end
    empty_signal = (fifo_q.size() == 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fifo_q.delete();
    exp_q.delete();
    empty_signal = 1'b1;
    n_corr   = 0;
    n_uncorr = 0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic drain(input int bound);
    int n = 0;
    data_ready = 1'b1;
    while ((exp_q.size() != 0) && (n < bound)) begin
      tick();
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    logic [31:0] hold;
    exp_t        e;

    // Reset state
    do_reset();
    chk("rst_read", s_rd, 1'b0);
    chk("rst_valid", s_vld, 1'b0);
    chk("rst_data", s_dat, 32'h0);
    chk("rst_corr", s_corr, 1'b0);
    chk("rst_uncorr", s_uncorr, 1'b0);
    chk("rst_ccnt", s_ccnt, 8'h00);
    chk("rst_ucnt", s_ucnt, 8'h00);

    // Clean word: read, then valid two cycles later
    data_ready = 1'b1;
    e = '{d: 32'h1, c: 1'b0, u: 1'b0};
    load(38'h0000000007, e);
    tick();
    chk("t1_read", s_rd, 1'b1);
    chk("t1_valid_n", s_vld, 1'b0);
    tick();
    chk("t1_read_n1", s_rd, 1'b0);
    chk("t1_valid_n1", s_vld, 1'b0);
    tick();
    chk("t1_valid_n2", s_vld, 1'b1);
    chk("t1_data_n2", s_dat, 32'h1);
    drain(10);

    // Single error on a parity-adjacent data bit
    e = '{d: 32'h1, c: 1'b1, u: 1'b0};
    load(38'h0000000003, e);
    drain(10);
    tick();
    chk("t2_ccnt", s_ccnt, exp_cnt(n_corr));

    // Uncorrectable syndrome 39, raw extraction
    e = '{d: 32'h04000004, c: 1'b0, u: 1'b1};
    load(38'h0100000020, e);
    drain(10);
    tick();
    chk("t3_ucnt", s_ucnt, exp_cnt(n_uncorr));
    chk("t3_ccnt", s_ccnt, exp_cnt(n_corr));

    // Backpressure: 5 queued, only 2 reads while stalled
    do_reset();
    data_ready = 1'b0;
    for (int i = 0; i < 5; i++) gen_word(0);
    n_reads = 0;
    repeat (8) tick();
    chk("stall_reads", n_reads, 2);
    chk("stall_read_low", s_rd, 1'b0);
    chk("stall_valid", s_vld, 1'b1);
    chk("stall_head", s_dat, exp_q[0].d);
    hold = s_dat;
    repeat (2) tick();
    chk("stall_stable", s_dat, hold);
    data_ready = 1'b1;
    n_del = 0;
    repeat (5) tick();
    chk("burst_delivered", n_del, 5);
    chk("burst_left", exp_q.size(), 0);

    // Reset with a word buffered and a read in flight
    do_reset();
    data_ready = 1'b0;
    for (int i = 0; i < 5; i++) gen_word(1);
    tick();
    tick();
    reset = 1'b1;
    tick();
    chk("mid_pre_valid", s_vld, 1'b1);
    chk("mid_read_in_reset", s_rd, 1'b0);
    reset = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    empty_signal  = 1'b1;
    n_corr        = 0;
    n_uncorr      = 0;
    decode_signal = 1'b1;
    data_input    = 38'h0000000003;
    tick();
    chk("mid_valid", s_vld, 1'b0);
    chk("mid_ccnt", s_ccnt, 8'h00);
    tick();
    chk("spurious_valid", s_vld, 1'b0);
    chk("spurious_ccnt", s_ccnt, 8'h00);

    // Randomized traffic with random backpressure
    do_reset();
    for (int w = 0; w < 200;) begin
      data_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 1) == 1 && fifo_q.size() < 8) begin
        gen_word(int'($urandom_range(0, 2)));
        w++;
      end
      tick();
    end
    drain(100);
    tick();
    chk("rand_ccnt", s_ccnt, exp_cnt(n_corr));
    chk("rand_ucnt", s_ucnt, exp_cnt(n_uncorr));

    // Counter saturation
    do_reset();
    data_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      gen_word(1);
      tick();
    end
    drain(50);
    tick();
    chk("sat_ccnt", s_ccnt, exp_cnt(n_corr));
    chk("sat_ucnt", s_ucnt, exp_cnt(n_uncorr));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
